fmm_reduce_kernel_mac_pipe: RTL and testbench

Parametrised, pipelined successor to the kernel's combinational 31x31 unsigned multiplier.
- Adds configurable pipeline depth, per-transaction signed/unsigned mode, optional running accumulation with frame-end clear, and a valid/ready handshake with backpressure.
- Sits between the FMM reduce datapath's operand fetch and its reduction/writeback stage.

---
 rtl/fmm_reduce_kernel_mac_pipe_if.sv | 30 +++
 rtl/fmm_reduce_kernel_mac_pipe.sv | 142 ++++++++++++++
 tb/tb_fmm_reduce_kernel_mac_pipe.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/fmm_reduce_kernel_mac_pipe_if.sv
// Handshake bundle for the pipelined multiply-accumulate kernel.
// master: upstream/downstream side driving operands and out_ready.
// slave:  the MAC pipe itself.
interface fmm_reduce_kernel_mac_pipe_if #(
    parameter int unsigned DIN0_WIDTH = 31,
    parameter int unsigned DIN1_WIDTH = 31,
    parameter int unsigned DOUT_WIDTH = 62
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DIN0_WIDTH-1:0] din0;
    logic [DIN1_WIDTH-1:0] din1;
    logic                  in_signed;
    logic                  in_acc;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [DOUT_WIDTH-1:0] dout;
    logic                  out_last;

    modport master (
        output in_valid, din0, din1, in_signed, in_acc, in_last, out_ready,
        input  in_ready, out_valid, dout, out_last
    );

    modport slave (
        input  in_valid, din0, din1, in_signed, in_acc, in_last, out_ready,
        output in_ready, out_valid, dout, out_last
    );
endinterface

// File: rtl/fmm_reduce_kernel_mac_pipe.sv
// Pipelined signed/unsigned multiplier with optional running accumulation.
// Product is formed at the input, carried through NUM_STAGE-1 middle stages,
// and folded into the accumulator on entry to the final (output) stage.
module fmm_reduce_kernel_mac_pipe #(
    parameter int unsigned DIN0_WIDTH = 31,
    parameter int unsigned DIN1_WIDTH = 31,
    parameter int unsigned DOUT_WIDTH = 62,
    parameter int unsigned NUM_STAGE  = 3
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst,
    fmm_reduce_kernel_mac_pipe_if.slave   bus
);
    localparam int unsigned PW   = DIN0_WIDTH + DIN1_WIDTH;
    localparam int unsigned MidN = (NUM_STAGE > 1) ? NUM_STAGE - 1 : 1;

    logic                  advance;
    logic [PW-1:0]         op0_ext;
    logic [PW-1:0]         op1_ext;
    logic [PW-1:0]         prod_full;
    logic [DOUT_WIDTH-1:0] prod_in;

    // Middle stages: product plus the flags that travel with it.
    logic                  mid_valid_q [MidN];
    logic                  mid_valid_d [MidN];
    logic [DOUT_WIDTH-1:0] mid_prod_q  [MidN];
    logic [DOUT_WIDTH-1:0] mid_prod_d  [MidN];
    logic                  mid_acc_q   [MidN];
    logic                  mid_acc_d   [MidN];
    logic                  mid_last_q  [MidN];
    logic                  mid_last_d  [MidN];

    // Final stage inputs and state.
    logic                  fin_valid;
    logic [DOUT_WIDTH-1:0] fin_prod;
    logic                  fin_acc;
    logic                  fin_last;
    logic [DOUT_WIDTH-1:0] sum;
    logic                  out_valid_q, out_valid_d;
    logic [DOUT_WIDTH-1:0] dout_q, dout_d;
    logic                  out_last_q, out_last_d;
    logic [DOUT_WIDTH-1:0] acc_q, acc_d;

    assign advance       = !out_valid_q || bus.out_ready;
    assign bus.in_ready  = advance;
    assign bus.out_valid = out_valid_q;
    assign bus.dout      = dout_q;
    assign bus.out_last  = out_last_q;

    // Extend both operands to full product width; a PW x PW multiply taken
    // modulo 2^PW is then correct for both signed and unsigned operands.
    always_comb begin
        op0_ext   = {{DIN1_WIDTH{bus.in_signed & bus.din0[DIN0_WIDTH-1]}}, bus.din0};
        op1_ext   = {{DIN0_WIDTH{bus.in_signed & bus.din1[DIN1_WIDTH-1]}}, bus.din1};
        prod_full = op0_ext * op1_ext;
    end

    if (DOUT_WIDTH <= PW) begin : g_trunc
        assign prod_in = prod_full[DOUT_WIDTH-1:0];
    end else begin : g_ext
        assign prod_in = {{(DOUT_WIDTH - PW){bus.in_signed & prod_full[PW-1]}}, prod_full};
    end

    // With a single stage the final stage takes the live input directly.
    if (NUM_STAGE == 1) begin : g_direct
        assign fin_valid = bus.in_valid;
        assign fin_prod  = prod_in;
        assign fin_acc   = bus.in_acc;
        assign fin_last  = bus.in_last;
    end else begin : g_piped
        assign fin_valid = mid_valid_q[MidN-1];
        assign fin_prod  = mid_prod_q[MidN-1];
        assign fin_acc   = mid_acc_q[MidN-1];
        assign fin_last  = mid_last_q[MidN-1];
    end

    // Middle-stage shift: hold on stall, shift one place on advance.
    always_comb begin
        for (int i = 0; i < MidN; i++) begin
            mid_valid_d[i] = mid_valid_q[i];
            mid_prod_d[i]  = mid_prod_q[i];
            mid_acc_d[i]   = mid_acc_q[i];
            mid_last_d[i]  = mid_last_q[i];
        end
        if (advance) begin
            mid_valid_d[0] = bus.in_valid;
            mid_prod_d[0]  = prod_in;
            mid_acc_d[0]   = bus.in_acc;
            mid_last_d[0]  = bus.in_last;
            for (int i = 1; i < MidN; i++) begin
                mid_valid_d[i] = mid_valid_q[i-1];
                mid_prod_d[i]  = mid_prod_q[i-1];
                mid_acc_d[i]   = mid_acc_q[i-1];
                mid_last_d[i]  = mid_last_q[i-1];
            end
        end
    end

    // Final stage: accumulate or pass through; acc only moves on a valid entry.
    always_comb begin
        sum         = fin_acc ? acc_q + fin_prod : fin_prod;
        out_valid_d = out_valid_q;
        dout_d      = dout_q;
        out_last_d  = out_last_q;
        acc_d       = acc_q;
        if (advance) begin
            out_valid_d = fin_valid;
            if (fin_valid) begin
                dout_d     = sum;
                out_last_d = fin_last;
                acc_d      = fin_last ? '0 : sum;
            end
        end
    end

    // Pipeline and accumulator registers with synchronous reset.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            for (int i = 0; i < MidN; i++) begin
                mid_valid_q[i] <= 1'b0;
                mid_prod_q[i]  <= '0;
                mid_acc_q[i]   <= 1'b0;
                mid_last_q[i]  <= 1'b0;
            end
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            out_last_q  <= 1'b0;
            acc_q       <= '0;
        end else begin
            for (int i = 0; i < MidN; i++) begin
                mid_valid_q[i] <= mid_valid_d[i];
                mid_prod_q[i]  <= mid_prod_d[i];
                mid_acc_q[i]   <= mid_acc_d[i];
                mid_last_q[i]  <= mid_last_d[i];
            end
            out_valid_q <= out_valid_d;
            dout_q      <= dout_d;
            out_last_q  <= out_last_d;
            acc_q       <= acc_d;
        end
    end
endmodule

// File: tb/tb_fmm_reduce_kernel_mac_pipe.sv
// Scoreboard bench: drivers push expected results, negedge monitors pop and compare.
module tb_fmm_reduce_kernel_mac_pipe;
    logic ap_clk = 1'b0;
    logic ap_rst = 1'b1;
    always #5 ap_clk = ~ap_clk;

    fmm_reduce_kernel_mac_pipe_if #(.DIN0_WIDTH(31), .DIN1_WIDTH(31), .DOUT_WIDTH(62)) bus ();
    fmm_reduce_kernel_mac_pipe_if #(.DIN0_WIDTH(31), .DIN1_WIDTH(31), .DOUT_WIDTH(8)) bus8 ();

    fmm_reduce_kernel_mac_pipe u_dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (bus)
    );

    fmm_reduce_kernel_mac_pipe #(.DOUT_WIDTH(8)) u_dut8 (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (bus8)
    );

    typedef struct packed {
        logic [61:0] d;
        logic        l;
    } exp_t;

    exp_t        exp_q[$];
    logic [8:0]  exp8_q[$];
    int          total = 0;
    int          bad = 0;
    int          hold = 0;
    logic        stalled_prev = 1'b0;
    logic [61:0] dout_prev = '0;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, req, $time);
        end
    endfunction

    // Main DUT monitor.
    always @(negedge ap_clk) begin
        exp_t e;
        if (ap_rst) begin
            stalled_prev = 1'b0;
        end else begin
            check("in_ready", {63'd0, bus.in_ready}, {63'd0, !bus.out_valid || bus.out_ready});
            if (stalled_prev) begin
                check("stall_valid", {63'd0, bus.out_valid}, 64'd1);
                check("stall_dout", {2'd0, bus.dout}, {2'd0, dout_prev});
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got 0x%0h want none", bus.dout);
                end else begin
                    e = exp_q.pop_front();
                    check("dout", {2'd0, bus.dout}, {2'd0, e.d});
                    check("out_last", {63'd0, bus.out_last}, {63'd0, e.l});
                end
            end
            stalled_prev = bus.out_valid && !bus.out_ready;
            dout_prev    = bus.dout;
        end
    end

    // Narrow-output DUT monitor.
    always @(negedge ap_clk) begin
        logic [8:0] e8;
        if (!ap_rst && bus8.out_valid && bus8.out_ready) begin
            if (exp8_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out8: got 0x%0h want none", bus8.dout);
            end else begin
                e8 = exp8_q.pop_front();
                check("dout8", {56'd0, bus8.dout}, {56'd0, e8[8:1]});
                check("out_last8", {63'd0, bus8.out_last}, {63'd0, e8[0]});
            end
        end
    end

    task automatic send(input logic [30:0] a, input logic [30:0] b, input logic sgn,
                        input logic acc, input logic last, input logic [61:0] ed,
                        input logic el);
        exp_t e;
        bus.din0      = a;
        bus.din1      = b;
        bus.in_signed = sgn;
        bus.in_acc    = acc;
        bus.in_last   = last;
        bus.in_valid  = 1'b1;
        for (int n = 0; n < 64; n++) begin
            bus.out_ready = (hold == 0);
            if (hold > 0) hold--;
            #1;
            if (bus.in_ready) begin
                e.d = ed;
                e.l = el;
                exp_q.push_back(e);
                @(posedge ap_clk);
                #1;
                bus.in_valid = 1'b0;
                return;
            end
            @(posedge ap_clk);
            #1;
        end
        total++;
        bad++;
        $display("FAIL send_timeout: got in_ready=0 want accept within 64 cycles");
        bus.in_valid = 1'b0;
    endtask

    task automatic send8(input logic [30:0] a, input logic [30:0] b, input logic acc,
                         input logic last, input logic [7:0] ed, input logic el);
        bus8.din0      = a;
        bus8.din1      = b;
        bus8.in_signed = 1'b0;
        bus8.in_acc    = acc;
        bus8.in_last   = last;
        bus8.in_valid  = 1'b1;
        #1;
        if (!bus8.in_ready) begin
            total++;
            bad++;
            $display("FAIL send8_ready: got 0 want 1");
        end
        exp8_q.push_back({ed, el});
        @(posedge ap_clk);
        #1;
        bus8.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            bus.out_ready = (hold == 0);
            if (hold > 0) hold--;
            @(posedge ap_clk);
            #1;
        end
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.din0       = '0;
        bus.din1       = '0;
        bus.in_signed  = 1'b0;
        bus.in_acc     = 1'b0;
        bus.in_last    = 1'b0;
        bus.out_ready  = 1'b1;
        bus8.in_valid  = 1'b0;
        bus8.din0      = '0;
        bus8.din1      = '0;
        bus8.in_signed = 1'b0;
        bus8.in_acc    = 1'b0;
        bus8.in_last   = 1'b0;
        bus8.out_ready = 1'b1;

        repeat (3) @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_dout", {2'd0, bus.dout}, 64'd0);
        check("rst_out_last", {63'd0, bus.out_last}, 64'd0);
        check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        check("rst_out_valid8", {63'd0, bus8.out_valid}, 64'd0);

        // Unsigned max with latency and one-cycle-wide out_valid.
        send(31'h7FFFFFFF, 31'h7FFFFFFF, 1'b0, 1'b0, 1'b0, 62'h3FFFFFFF00000001, 1'b0);
        check("lat_c1", {63'd0, bus.out_valid}, 64'd0);
        idle(1);
        check("lat_c2", {63'd0, bus.out_valid}, 64'd0);
        idle(1);
        check("lat_c3", {63'd0, bus.out_valid}, 64'd1);
        idle(1);
        check("lat_c4", {63'd0, bus.out_valid}, 64'd0);

        // Wrap on the 8-bit build.
        send8(31'd16, 31'd16, 1'b1, 1'b0, 8'h00, 1'b0);
        send8(31'd16, 31'd1, 1'b1, 1'b1, 8'h10, 1'b1);

        // Signed vs unsigned on the same operands; last clears acc.
        send(31'h7FFFFFFF, 31'd3, 1'b1, 1'b0, 1'b0, 62'h3FFFFFFFFFFFFFFD, 1'b0);
        send(31'h7FFFFFFF, 31'd3, 1'b0, 1'b0, 1'b1, 62'h17FFFFFFD, 1'b1);

        // Accumulate frame then a new frame.
        send(31'd2, 31'd5, 1'b0, 1'b1, 1'b0, 62'd10, 1'b0);
        send(31'd3, 31'd7, 1'b0, 1'b1, 1'b0, 62'd31, 1'b0);
        send(31'd1, 31'd1, 1'b0, 1'b1, 1'b0, 62'd32, 1'b0);
        send(31'd4, 31'd4, 1'b0, 1'b1, 1'b1, 62'd48, 1'b1);
        send(31'd1, 31'd1, 1'b0, 1'b1, 1'b0, 62'd1, 1'b0);
        idle(6);

        // Build acc=48, put three in flight, then reset.
        send(31'd2, 31'd5, 1'b0, 1'b0, 1'b0, 62'd10, 1'b0);
        send(31'd3, 31'd7, 1'b0, 1'b1, 1'b0, 62'd31, 1'b0);
        send(31'd1, 31'd1, 1'b0, 1'b1, 1'b0, 62'd32, 1'b0);
        send(31'd4, 31'd4, 1'b0, 1'b1, 1'b0, 62'd48, 1'b0);
        idle(6);
        send(31'd1, 31'd1, 1'b0, 1'b1, 1'b0, 62'd49, 1'b0);
        send(31'd1, 31'd1, 1'b0, 1'b1, 1'b0, 62'd50, 1'b0);
        send(31'd1, 31'd1, 1'b0, 1'b1, 1'b0, 62'd51, 1'b0);
        ap_rst = 1'b1;
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        exp_q.delete();
        check("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        idle(5);
        send(31'd2, 31'd2, 1'b0, 1'b1, 1'b0, 62'd4, 1'b0);
        idle(5);

        // Backpressure mid-stream.
        for (int i = 1; i <= 8; i++) begin
            if (i == 4) hold = 5;
            send(31'(i), 31'(i), 1'b0, 1'b0, 1'b0, 62'(i * i), 1'b0);
        end
        idle(12);

        for (int n = 0; n < 100 && (exp_q.size() != 0 || exp8_q.size() != 0); n++) idle(1);
        if (exp_q.size() != 0 || exp8_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d/%0d pending want 0", exp_q.size(), exp8_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
